audio_ram_scheduler: RTL and testbench
======================================

// Module: audio_ram_scheduler
// PURPOSE
//  Shares one DDR RAM interface wrapper port between the record path (codec ADC samples) and the playback path (DAC samples).
//  Edge-detects the codec s_end/s_req sample strobes and queues one pending write and one pending read.
//  Arbitrates between them, runs the wrapper write/read handshakes, and owns the record/playback address pointers.
//  Sits between the audio interface and the RAM interface wrapper, replacing ad-hoc sequencing in the top controller.
// PARAMETERS
//  ADDR_W      26    RAM word address width
//  DATA_W      16    audio sample / RAM word width
//  RD_TIMEOUT  1023  cycles to wait for rd_data_pres before aborting a read
// PORTS
//  clk              in   1       system clock (RAM wrapper user clock); all logic on posedge
//  reset            in   1       asynchronous, active-high reset
//  rec_en           in   1       record enable (level); rising edge restarts recording at address 0
//  play_en          in   1       playback enable (level); rising edge restarts playback at address 0
//  s_end            in   1       codec ADC sample-complete strobe (level, synced to clk upstream)
//  s_req            in   1       codec DAC sample-request strobe (level, synced to clk upstream)
//  audio_in         in   DATA_W  ADC sample, valid at s_end rising edge
//  audio_out        out  DATA_W  DAC sample presented to codec
//  max_ram_address  in   ADDR_W  last usable RAM address
//  ram_rdy          in   1       wrapper ready; no new transaction starts while low
//  ram_address      out  ADDR_W  wrapper address
//  ram_data_in      out  DATA_W  wrapper write data
//  ram_write_enable out  1       one-cycle write pulse
//  ram_read_request out  1       read request, held until data present
//  ram_rd_data_pres in   1       wrapper read data valid
//  ram_data_out     in   DATA_W  wrapper read data
//  ram_read_ack     out  1       one-cycle read acknowledge
//  rec_len          out  ADDR_W+1  samples recorded since last rec_en rise (saturating)
//  overrun          out  1       sticky: ADC sample lost
//  underrun         out  1       sticky: DAC request served with stale data
//  rd_error         out  1       sticky: read timed out
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; wr_ptr=rd_ptr=0; rec_len=0; pending flags, prefetch_valid and sticky flags 0.
//  Strobes: rising edge = input high now and low last cycle (previous value registered).
//  On s_end rise with rec_en=1:
//   - latch audio_in into wr_buf and set wr_pend.
//   - If wr_pend is already set, set overrun; the newer sample replaces the older one.
//  On s_req rise with play_en=1:
//   - If prefetch_valid: audio_out<=prefetch_buf the next cycle and clear prefetch_valid.
//   - Else: hold audio_out and set underrun.
//   - In both cases set rd_pend, unless rec_len==0; then audio_out<=0 and no read is issued.
//  FSM states: IDLE, WRITE, READ_REQ, READ_WAIT.
//   - IDLE: if ram_rdy and any flag is pending, grant one. If both are pending, alternate, starting with write after reset.
//   - WRITE (1 cycle): ram_write_enable=1, ram_address=wr_ptr, ram_data_in=wr_buf.
//     Clear wr_pend; wr_ptr<=(wr_ptr==max_ram_address)?0:wr_ptr+1; rec_len++ saturating at max_ram_address+1. Go to IDLE.
//   - READ_REQ (1 cycle): ram_address=rd_ptr, ram_read_request=1. Go to READ_WAIT; timeout counter=0.
//   - READ_WAIT: ram_read_request held at 1.
//     On ram_rd_data_pres: prefetch_buf<=ram_data_out, prefetch_valid=1, ram_read_ack=1 for 1 cycle, request drops.
//     Then clear rd_pend; rd_ptr<=(rd_ptr+1==rec_len)?0:rd_ptr+1; go to IDLE.
//     If RD_TIMEOUT elapses first: set rd_error, drop the request, clear rd_pend, leave rd_ptr unchanged, go to IDLE.
//  ram_address holds its last value outside transactions.
//  Write latency: s_end rise to ram_write_enable is 2 cycles minimum (edge detect, then IDLE grant).
//  Enable transitions:
//   - rec_en rise: wr_ptr<=0, rec_len<=0, wr_pend<=0.
//   - play_en rise: rd_ptr<=0, prefetch_valid<=0, rd_pend<=1 (prime the prefetch).
//   - Deasserting either enable mid-transaction: the in-flight transaction completes and nothing further is queued for that path.
//  Address and length widths:
//   - Pointer arithmetic is ADDR_W wide, with no overflow past max_ram_address.
//   - rec_len is ADDR_W+1 wide so a completely full buffer is representable.
//  Reset mid-transaction: all handshake outputs drop asynchronously; the wrapper must tolerate an aborted request.
// STRUCTURE
//  audio_ram_pkg: FSM state encoding, ADDR_W/DATA_W defaults, RD_TIMEOUT counter width.
//  Sub-module strobe_rise_detect (clk, reset, in, rise), instanced for s_end, s_req, rec_en and play_en.
//  FSM, pointers and flags live in this module.
// TESTING
//  1. Reset, rec_en=1, 4 s_end pulses with audio_in=0x0001..0x0004.
//     Expect 4 write pulses at addresses 0..3 with data 0x0001..0x0004, and rec_len=4.
//  2. After test 1, play_en=1 then 6 s_req pulses.
//     Expect reads at addresses 0,1,2,3,0,1 and audio_out sequence 0x0001,0x0002,0x0003,0x0004,0x0001,0x0002.
//  3. max_ram_address=3, 5 writes.
//     Expect addresses 0,1,2,3,0; rec_len saturates at 4; overrun stays 0.
//  4. ram_rdy=0 while 2 s_end rises occur.
//     Expect overrun=1; after ram_rdy=1, exactly one write with the second sample.
//  5. Hold ram_rd_data_pres=0 for a read.
//     Expect rd_error=1 after RD_TIMEOUT cycles, ram_read_request=0, and FSM back in IDLE.
//  6. s_end and s_req rise in the same cycle while both paths are enabled.
//     Expect a write then a read (alternation), and reset asserted mid-READ_WAIT returns all outputs to 0 immediately.

Source files
------------

// File: rtl/audio_ram_pkg.sv
// audio_ram_pkg: shared state encoding and default sizing for the audio RAM scheduler
package audio_ram_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;
  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 16;
  localparam int RD_TIMEOUT_DEF = 1023;
  function automatic int tmo_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/strobe_rise_detect.sv
// strobe_rise_detect: one-cycle pulse when a level input goes from low to high
module strobe_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev <= 1'b0;
    else prev <= in;
  assign rise = in & ~prev;
endmodule

// File: rtl/audio_ram_scheduler.sv
// audio_ram_scheduler: shares one RAM wrapper port between codec record writes and playback reads
module audio_ram_scheduler
  import audio_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              s_end,
  input  logic              s_req,
  input  logic [DATA_W-1:0] audio_in,
  output logic [DATA_W-1:0] audio_out,
  input  logic [ADDR_W-1:0] max_ram_address,
  input  logic              ram_rdy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_request,
  input  logic              ram_rd_data_pres,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              ram_read_ack,
  output logic [ADDR_W:0]   rec_len,
  output logic              overrun,
  output logic              underrun,
  output logic              rd_error
);
  localparam int TW = tmo_w(RD_TIMEOUT);
  state_t state, nxt;
  logic end_rise, req_rise, rec_rise, play_rise;
  logic [DATA_W-1:0] wr_buf, pf_buf;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] rec_max;
  logic [TW-1:0] tmo;
  logic wr_pend, rd_pend, pf_valid, prefer_rd, ack_q;
  logic grant_wr, grant_rd, rd_done, rd_tmo;
  strobe_rise_detect u_end  (.clk(clk), .reset(reset), .in(s_end),   .rise(end_rise));
  strobe_rise_detect u_req  (.clk(clk), .reset(reset), .in(s_req),   .rise(req_rise));
  strobe_rise_detect u_rec  (.clk(clk), .reset(reset), .in(rec_en),  .rise(rec_rise));
  strobe_rise_detect u_play (.clk(clk), .reset(reset), .in(play_en), .rise(play_rise));
  assign rec_max = {1'b0, max_ram_address} + 1'b1;
  // prefer_rd flips on every grant so simultaneous requests alternate, write first
  assign grant_wr = state == IDLE && ram_rdy && wr_pend && (!rd_pend || !prefer_rd);
  assign grant_rd = state == IDLE && ram_rdy && rd_pend && !grant_wr;
  assign rd_done = state == READ_WAIT && ram_rd_data_pres;
  assign rd_tmo = state == READ_WAIT && !ram_rd_data_pres && tmo == TW'(RD_TIMEOUT - 1);
  assign ram_write_enable = state == WRITE;
  assign ram_read_request = state == READ_REQ || state == READ_WAIT;
  assign ram_data_in = wr_buf;
  assign ram_read_ack = ack_q;
  always_comb begin
    nxt = grant_wr ? WRITE : grant_rd ? READ_REQ : state == WRITE ? IDLE :
          state == READ_REQ ? READ_WAIT : (rd_done || rd_tmo) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {wr_buf, pf_buf, audio_out, ram_address} <= '0;
      {wr_ptr, rd_ptr, rec_len, tmo} <= '0;
      {wr_pend, rd_pend, pf_valid, prefer_rd, ack_q} <= '0;
      {overrun, underrun, rd_error} <= '0;
    end else begin
      if (state == WRITE) begin
        wr_ptr <= (wr_ptr == max_ram_address) ? '0 : wr_ptr + 1'b1;
        rec_len <= (rec_len == rec_max) ? rec_len : rec_len + 1'b1;
        wr_pend <= 1'b0;
      end
      if (grant_wr) ram_address <= wr_ptr;
      if (grant_rd) ram_address <= rd_ptr;
      if (grant_wr || grant_rd) prefer_rd <= grant_wr;
      tmo <= (state == READ_WAIT) ? tmo + 1'b1 : '0;
      ack_q <= rd_done;
      if (rd_done) begin
        pf_buf <= ram_data_out;
        pf_valid <= 1'b1;
        rd_ptr <= ({1'b0, rd_ptr} + 1'b1 == rec_len) ? '0 : rd_ptr + 1'b1;
      end
      if (rd_done || rd_tmo) rd_pend <= 1'b0;
      if (rd_tmo) rd_error <= 1'b1;
      // enable edges and fresh strobes come last so they win over completion updates
      if (rec_rise) begin
        wr_ptr <= '0;
        rec_len <= '0;
        wr_pend <= 1'b0;
      end
      if (play_rise) begin
        rd_ptr <= '0;
        pf_valid <= 1'b0;
        rd_pend <= 1'b1;
      end
      if (end_rise && rec_en) begin
        wr_buf <= audio_in;
        wr_pend <= 1'b1;
        if (wr_pend && state != WRITE) overrun <= 1'b1;
      end
      if (req_rise && play_en) begin
        if (rec_len == '0) audio_out <= '0;
        else begin
          if (pf_valid) begin
            audio_out <= pf_buf;
            pf_valid <= 1'b0;
          end else underrun <= 1'b1;
          rd_pend <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_ram_scheduler.sv
// tb_audio_ram_scheduler: scenario tasks against a RAM wrapper model and a sample-buffer reference
module tb_audio_ram_scheduler;
  localparam int AW = 26;
  localparam int DW = 16;
  localparam int TMO = 1023;
  logic clk = 0, reset = 1, rec_en = 0, play_en = 0, s_end = 0, s_req = 0, ram_rdy = 1;
  logic [DW-1:0] audio_in = 0, audio_out, ram_data_in;
  logic [DW-1:0] ram_data_out = 0;
  logic [AW-1:0] max_ram_address = 63, ram_address;
  logic ram_write_enable, ram_read_request, ram_read_ack, overrun, underrun, rd_error;
  logic ram_rd_data_pres = 0;
  logic [AW:0] rec_len;
  logic [DW-1:0] mem [0:63];
  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0] rq[$];
  int ev[$];
  bit respond = 1, rd_seen = 0;
  int dly = 0;
  int errors = 0, checks = 0;

  audio_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .play_en(play_en), .s_end(s_end), .s_req(s_req),
    .audio_in(audio_in), .audio_out(audio_out), .max_ram_address(max_ram_address), .ram_rdy(ram_rdy),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .ram_read_request(ram_read_request), .ram_rd_data_pres(ram_rd_data_pres), .ram_data_out(ram_data_out),
    .ram_read_ack(ram_read_ack), .rec_len(rec_len), .overrun(overrun), .underrun(underrun), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  // RAM wrapper model: stores writes, answers reads after a random delay unless told to stall
  always @(negedge clk) begin
    if (ram_write_enable) begin
      wq.push_back({ram_address, ram_data_in});
      ev.push_back(0);
      mem[ram_address[5:0]] = ram_data_in;
    end
    if (ram_read_request && !rd_seen) begin
      rq.push_back(ram_address);
      ev.push_back(1);
      rd_seen = 1;
      dly = $urandom_range(0, 3);
    end
    if (ram_read_request && respond && !ram_rd_data_pres) begin
      if (dly == 0) begin
        ram_rd_data_pres = 1;
        ram_data_out = mem[ram_address[5:0]];
      end else dly--;
    end
    if (!ram_read_request) begin
      rd_seen = 0;
      ram_rd_data_pres = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; rec_en = 0; play_en = 0; s_end = 0; s_req = 0; audio_in = 0;
    ram_rdy = 1; respond = 1; max_ram_address = 63;
    cyc(2);
    reset = 0;
    wq.delete(); rq.delete(); ev.delete();
    cyc(1);
  endtask

  task automatic pulse_end(input logic [DW-1:0] d);
    audio_in = d; s_end = 1;
    cyc(1);
    s_end = 0;
    cyc(7);
  endtask

  task automatic pulse_req();
    s_req = 1;
    cyc(1);
    s_req = 0;
    cyc(9);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ram_write_enable); end
    checks++; if (ram_read_request !== 1'b0) begin errors++; $display("FAIL reset_rreq got %b want 0", ram_read_request); end
    checks++; if (ram_read_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ram_read_ack); end
    checks++; if (ram_address !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", ram_address); end
    checks++; if (ram_data_in !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", ram_data_in); end
    checks++; if (audio_out !== '0) begin errors++; $display("FAIL reset_audio got %h want 0", audio_out); end
    checks++; if (rec_len !== '0) begin errors++; $display("FAIL reset_reclen got %0d want 0", rec_len); end
    checks++; if ({overrun, underrun, rd_error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overrun, underrun, rd_error}); end
  endtask

  // record n samples into a buffer of maxa+1 words, then play len+2 samples and compare with the model buffer
  task automatic test_record_play(input int maxa, input int n, input bit fixed);
    logic [DW-1:0] model [0:63];
    logic [DW-1:0] smp[$];
    logic [DW-1:0] d;
    int len, m;
    do_reset();
    max_ram_address = AW'(maxa);
    rec_en = 1;
    cyc(2);
    for (int k = 0; k < n; k++) begin
      d = fixed ? DW'(k + 1) : DW'($urandom);
      smp.push_back(d);
      model[k % (maxa + 1)] = d;
      pulse_end(d);
    end
    len = (n < maxa + 1) ? n : maxa + 1;
    checks++; if (wq.size() != n) begin errors++; $display("FAIL wr_count got %0d want %0d", wq.size(), n); end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      checks++;
      if (wq[k] !== {AW'(k % (maxa + 1)), smp[k]}) begin
        errors++; $display("FAIL wr_%0d got addr %0d data %h want addr %0d data %h", k, wq[k][AW+DW-1:DW], wq[k][DW-1:0], k % (maxa + 1), smp[k]);
      end
    end
    checks++; if (rec_len !== (AW+1)'(len)) begin errors++; $display("FAIL rec_len got %0d want %0d", rec_len, len); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rec_overrun got %b want 0", overrun); end
    play_en = 1;
    cyc(10);
    m = len + 2;
    for (int j = 0; j < m; j++) begin
      pulse_req();
      checks++;
      if (audio_out !== model[j % len]) begin errors++; $display("FAIL play_%0d got %h want %h", j, audio_out, model[j % len]); end
    end
    for (int j = 0; j < m && j < rq.size(); j++) begin
      checks++;
      if (rq[j] !== AW'(j % len)) begin errors++; $display("FAIL rd_addr_%0d got %0d want %0d", j, rq[j], j % len); end
    end
    checks++; if (rq.size() < m) begin errors++; $display("FAIL rd_count got %0d want >=%0d", rq.size(), m); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL play_underrun got %b want 0", underrun); end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] d1, d2;
    d1 = DW'($urandom); d2 = DW'($urandom);
    do_reset();
    rec_en = 1;
    cyc(2);
    ram_rdy = 0;
    pulse_end(d1);
    pulse_end(d2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL ovr_stalled got %0d writes want 0", wq.size()); end
    ram_rdy = 1;
    cyc(6);
    checks++; if (wq.size() != 1) begin errors++; $display("FAIL ovr_count got %0d want 1", wq.size()); end
    checks++; if (wq.size() > 0 && wq[0] !== {AW'(0), d2}) begin errors++; $display("FAIL ovr_data got %h want %h", wq[0], {AW'(0), d2}); end
  endtask

  task automatic test_timeout();
    int t = 0, n = 0;
    do_reset();
    rec_en = 1;
    cyc(2);
    pulse_end(DW'($urandom));
    respond = 0;
    play_en = 1;
    while (!ram_read_request && t < 20) begin cyc(1); t++; end
    checks++; if (!ram_read_request) begin errors++; $display("FAIL tmo_start got no request want request"); end
    while (ram_read_request && n < 2000) begin cyc(1); n++; end
    checks++; if (n < TMO || n > TMO + 2) begin errors++; $display("FAIL tmo_len got %0d cycles want %0d..%0d", n, TMO, TMO + 2); end
    checks++; if (rd_error !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", rd_error); end
    checks++; if (ram_read_request !== 1'b0) begin errors++; $display("FAIL tmo_rreq got %b want 0", ram_read_request); end
    respond = 1;
    pulse_end(DW'($urandom));
    checks++; if (wq.size() != 2 || wq[1][AW+DW-1:DW] !== AW'(1)) begin errors++; $display("FAIL tmo_idle got %0d writes want 2 with second at addr 1", wq.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rec_en = 1;
    cyc(2);
    pulse_end(16'h00a1);
    pulse_end(16'h00b2);
    play_en = 1;
    cyc(10);
    ev.delete();
    audio_in = 16'h00c3; s_end = 1; s_req = 1;
    cyc(1);
    s_end = 0; s_req = 0;
    cyc(10);
    checks++; if (ev.size() < 2 || ev[0] != 0 || ev[1] != 1) begin errors++; $display("FAIL b2b_order got %0d events first %0d want write then read", ev.size(), ev.size() ? ev[0] : -1); end
    checks++; if (audio_out !== 16'h00a1) begin errors++; $display("FAIL b2b_audio got %h want 00a1", audio_out); end
    respond = 0;
    s_req = 1;
    cyc(1);
    s_req = 0;
    cyc(5);
    checks++; if (ram_read_request !== 1'b1) begin errors++; $display("FAIL b2b_wait got %b want 1", ram_read_request); end
    @(posedge clk);
    #1 reset = 1;
    #1;
    checks++; if ({ram_read_request, ram_write_enable, ram_read_ack} !== 3'b000) begin errors++; $display("FAIL b2b_rst_hs got %b want 000", {ram_read_request, ram_write_enable, ram_read_ack}); end
    checks++; if (ram_address !== '0 || audio_out !== '0 || rec_len !== '0) begin errors++; $display("FAIL b2b_rst_out got addr %h audio %h len %0d want 0", ram_address, audio_out, rec_len); end
    cyc(2);
    reset = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_record_play(63, 4, 1);
    test_record_play(3, 5, 1);
    for (int r = 0; r < 3; r++) test_record_play($urandom_range(2, 9), $urandom_range(2, 14), 0);
    test_overrun();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
